sd_emmc_dat_rx_ctrl: RTL and testbench
======================================

Name: sd_emmc_dat_rx_ctrl

Overview:
- Receive sequencer for the SD/eMMC DAT lines.
- Takes the pad-buffered DAT bus, waits for the start bit, and deserialises one data block into bytes.
- Checks the per-line CRC16 and end bit, and reports completion, CRC error or timeout.
- Sits between the DAT input buffers and the read-data FIFO/DMA; the command-layer FSM drives it.

Parameters:
- DATA_WIDTH, 4, DAT bus width; legal values are 1, 4, 8.
- BLKSZ_W, 12, width of the block-size field in bytes; maximum block is 2^BLKSZ_W-1 bytes.
- TIMEOUT_W, 24, width of the start-bit timeout counter.

Ports:
- clk  in  1  card clock domain; DAT is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms reception of one block.
- abort  in  1  level or pulse; terminates the current operation.
- blk_size  in  BLKSZ_W  block length in bytes; captured on start.
- timeout  in  TIMEOUT_W  start-bit wait limit in clk cycles; captured on start. 0 = wait forever.
- dat_i  in  DATA_WIDTH  buffered DAT lines.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
- rx_data  out  8  received byte.
- rx_valid  out  1  one-cycle strobe qualifying rx_data.
- done  out  1  one-cycle pulse at the end of the operation.
- crc_err  out  1  CRC mismatch on any line, or bad end bit. Valid with done; held until the next accepted start.
- timeout_err  out  1  no start bit within timeout. Valid with done; held until the next accepted start.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and CRC registers 0.
- States: IDLE -> WAIT_START -> DATA -> CRC -> END -> IDLE.
- IDLE:
  - start with blk_size!=0: capture blk_size and timeout, clear crc_err and timeout_err, go to WAIT_START.
  - start with blk_size==0: clear flags, pulse done next cycle, emit no data, stay IDLE.
- WAIT_START:
  - Start bit means every dat_i line is 0 in the same cycle. Partial zeros are ignored and waiting continues.
  - The wait counter increments every cycle spent here.
  - If timeout!=0 and the counter reaches timeout with no start bit: set timeout_err, pulse done, go to IDLE.
  - With start at cycle 0, timeout fires with done at cycle timeout+1.
  - The start-bit cycle is not data and is not CRC'd. Go to DATA.
- DATA:
  - Runs for blk_size*8/DATA_WIDTH cycles.
  - Byte packing is MSB first:
    - DATA_WIDTH=1: 8 cycles per byte, first bit = bit7.
    - DATA_WIDTH=4: 2 cycles per byte, first nibble = [7:4], dat_i[3] = MSB of the nibble.
    - DATA_WIDTH=8: 1 cycle per byte, rx_data = dat_i.
  - rx_valid pulses the cycle after the last bit of each byte is sampled; rx_data is stable while rx_valid=1.
  - Each line n feeds its own CRC16 (CCITT, x^16+x^12+x^5+1, init 0) with every DATA-state bit.
- CRC:
  - Runs for 16 cycles. Each line's received bit is compared MSB first with its computed CRC.
  - Any mismatch sets a sticky internal error.
- END:
  - One cycle. All lines must be 1, otherwise set the error.
  - Next cycle: pulse done, set crc_err = error, go to IDLE.
  - The last rx_valid therefore precedes done by 18 cycles.
- Errors do not suppress data delivery; the consumer discards the block on crc_err.
- start while busy is ignored; the captured blk_size and timeout are unchanged.
- abort in any non-IDLE state:
  - Go to IDLE next cycle. No done, no further rx_valid, flags unchanged.
  - abort and start in the same cycle: abort wins and start is dropped.
  - abort in IDLE has no effect.
- rst mid-operation behaves as reset: immediate IDLE, outputs 0, no done.
- Counters are sized for maximum blk_size*8 bit-cycles plus 16. There is no wrap inside a block.
- The timeout counter saturates.

Test Plan:
- DATA_WIDTH=4, blk_size=4, bytes A5 3C FF 00, correct per-line CRCs from the model, end=1111 -> rx_data A5,3C,FF,00 with 4 rx_valid 2 cycles apart; done 18 cycles after the last rx_valid; crc_err=0, timeout_err=0.
- Same block with DAT2 CRC bit 5 flipped -> all 4 bytes delivered; done with crc_err=1. Separately, end bit 1011 -> crc_err=1.
- timeout=100, dat_i held 1111 -> no rx_valid; done at cycle 101 after start; timeout_err=1, busy falls with done. timeout=0 with 10000 idle cycles -> no done.
- DATA_WIDTH=1, blk_size=512, incrementing pattern 00..FF twice, correct CRC -> 512 rx_valid every 8 cycles, bytes match; crc_err=0.
- start pulsed during DATA with a different blk_size -> ignored, original length completes. abort after byte 2 of 4 -> IDLE next cycle, no done, no more rx_valid; a new start is accepted.
- blk_size=0 start -> done next cycle, no rx_valid, flags 0. dat_i=0111 during WAIT_START -> not a start bit, waiting continues. rst asserted in CRC state -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sd_emmc_dat_rx.sv
// SD/eMMC DAT receive sequencer: start-bit wait, MSB-first deserialisation,
// per-line CRC16 check and end-bit check for one data block.

module sd_emmc_dat_rx_crc_lane (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic calc,
  input  logic chk,
  input  logic din,
  output logic crc_msb
);
  logic [15:0] crc;

  // CCITT x^16+x^12+x^5+1; during the check phase the register just shifts out MSB first
  always_ff @(posedge clk) begin
    if (rst || clr)
      crc <= '0;
    else if (calc)
      crc <= {crc[14:0], 1'b0} ^ ({16{crc[15] ^ din}} & 16'h1021);
    else if (chk)
      crc <= {crc[14:0], 1'b0};
  end

  assign crc_msb = crc[15];
endmodule

module sd_emmc_dat_rx_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int BLKSZ_W    = 12,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BLKSZ_W-1:0]    blk_size,
  input  logic [TIMEOUT_W-1:0]  timeout,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  busy,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  done,
  output logic                  crc_err,
  output logic                  timeout_err
);
  localparam int CW  = BLKSZ_W + 4;
  localparam int BPB = 8 / DATA_WIDTH;
  localparam int SH  = (DATA_WIDTH == 1) ? 3 : (DATA_WIDTH == 4) ? 1 : 0;

  // S_DONE is the cycle after the final check in which done is pulsed
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_END, S_DONE} state_t;
  state_t state, state_nxt;

  logic [BLKSZ_W-1:0]    blk_q;
  logic [TIMEOUT_W-1:0]  tmo_q, wait_cnt, wait_inc;
  logic [CW-1:0]         cnt, total_beats;
  logic [7:0]            sh, byte_nxt;
  logic [DATA_WIDTH-1:0] crc_msb;
  logic err, tmo_flag, zlen_pend;
  logic start_ok, all_zero, all_one, tmo_hit, last_beat, byte_end, crc_last;
  logic crc_clr, crc_calc, crc_chk;

  assign start_ok    = start && !abort;
  assign all_zero    = (dat_i == '0);
  assign all_one     = &dat_i;
  assign wait_inc    = (&wait_cnt) ? wait_cnt : wait_cnt + TIMEOUT_W'(1);
  assign tmo_hit     = (tmo_q != '0) && (wait_inc >= tmo_q);
  assign total_beats = CW'(blk_q) << SH;
  assign last_beat   = (cnt == total_beats - CW'(1));
  assign byte_end    = ((cnt % CW'(BPB)) == CW'(BPB - 1));
  assign crc_last    = (cnt == CW'(15));
  assign byte_nxt    = 8'({sh, dat_i});

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok && blk_size != '0) state_nxt = S_WAIT;
      S_WAIT: begin
        if (all_zero)     state_nxt = S_DATA;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      S_DATA: if (last_beat) state_nxt = S_CRC;
      S_CRC:  if (crc_last)  state_nxt = S_END;
      S_END:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_comb begin
    busy     = (state != S_IDLE);
    crc_clr  = (state == S_IDLE) && start_ok;
    crc_calc = (state == S_DATA);
    crc_chk  = (state == S_CRC);
  end

  for (genvar n = 0; n < DATA_WIDTH; n++) begin : g_lane
    sd_emmc_dat_rx_crc_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (crc_clr),
      .calc    (crc_calc),
      .chk     (crc_chk),
      .din     (dat_i[n]),
      .crc_msb (crc_msb[n])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q       <= '0;
      tmo_q       <= '0;
      wait_cnt    <= '0;
      cnt         <= '0;
      sh          <= '0;
      err         <= 1'b0;
      tmo_flag    <= 1'b0;
      zlen_pend   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      done        <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done      <= zlen_pend;
      rx_valid  <= 1'b0;
      zlen_pend <= 1'b0;
      case (state)
        S_IDLE: if (start_ok) begin
          blk_q       <= blk_size;
          tmo_q       <= timeout;
          wait_cnt    <= '0;
          cnt         <= '0;
          err         <= 1'b0;
          tmo_flag    <= 1'b0;
          crc_err     <= 1'b0;
          timeout_err <= 1'b0;
          zlen_pend   <= (blk_size == '0);
        end
        S_WAIT: begin
          wait_cnt <= wait_inc;
          if (!all_zero && tmo_hit) tmo_flag <= 1'b1;
        end
        S_DATA: begin
          sh  <= byte_nxt;
          cnt <= last_beat ? '0 : cnt + CW'(1);
          if (byte_end && !abort) begin
            rx_data  <= byte_nxt;
            rx_valid <= 1'b1;
          end
        end
        S_CRC: begin
          cnt <= cnt + CW'(1);
          if (dat_i != crc_msb) err <= 1'b1;
        end
        S_END: if (!all_one) err <= 1'b1;
        S_DONE: if (!abort) begin
          done        <= 1'b1;
          crc_err     <= err;
          timeout_err <= tmo_flag;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_emmc_dat_rx_ctrl.sv
// Bench for sd_emmc_dat_rx_ctrl: 4-bit and 1-bit instances driven from a
// block/CRC reference built from the byte list.

module tb_sd_emmc_dat_rx_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start4, start1, abort;
  logic [11:0] blk_size;
  logic [23:0] timeout;
  logic [3:0]  dat4;
  logic [0:0]  dat1;
  logic        busy4, rxv4, done4, ce4, te4;
  logic        busy1, rxv1, done1, ce1, te1;
  logic [7:0]  rx4, rx1;

  sd_emmc_dat_rx_ctrl #(.DATA_WIDTH(4), .BLKSZ_W(12), .TIMEOUT_W(24)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort), .blk_size(blk_size),
    .timeout(timeout), .dat_i(dat4), .busy(busy4), .rx_data(rx4), .rx_valid(rxv4),
    .done(done4), .crc_err(ce4), .timeout_err(te4));

  sd_emmc_dat_rx_ctrl #(.DATA_WIDTH(1), .BLKSZ_W(12), .TIMEOUT_W(24)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .blk_size(blk_size),
    .timeout(timeout), .dat_i(dat1), .busy(busy1), .rx_data(rx1), .rx_valid(rxv1),
    .done(done1), .crc_err(ce1), .timeout_err(te1));

  int n_cmp = 0, n_bad = 0, cyc_n = 0, act_w = 4;
  int dn, dcyc, t0, b100, b101;
  bit busy_seen;
  logic [7:0] data_q[$];
  logic [7:0] got[$];
  int beat_q[$];
  int vt[$];
  logic ce_a, te_a, busy_a;

  always_comb begin
    ce_a   = (act_w == 4) ? ce4   : ce1;
    te_a   = (act_w == 4) ? te4   : te1;
    busy_a = (act_w == 4) ? busy4 : busy1;
  end

  function automatic int crc_step(input int c, input int b);
    int fb, r;
    fb = ((c >> 15) & 1) ^ b;
    r  = (c << 1) & 32'hFFFF;
    return (fb != 0) ? (r ^ 32'h1021) : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc_n++;
    if (act_w == 4) begin
      if (rxv4)  begin got.push_back(rx4); vt.push_back(cyc_n); end
      if (done4) begin dn++; dcyc = cyc_n; end
      if (busy4) busy_seen = 1'b1;
    end else begin
      if (rxv1)  begin got.push_back(rx1); vt.push_back(cyc_n); end
      if (done1) begin dn++; dcyc = cyc_n; end
      if (busy1) busy_seen = 1'b1;
    end
  endtask

  task automatic clr_log();
    got.delete(); vt.delete(); dn = 0; dcyc = -1; busy_seen = 1'b0;
  endtask

  task automatic set_dat(input int v);
    if (act_w == 4) dat4 = v[3:0];
    else            dat1 = v[0:0];
  endtask

  task automatic pulse_start();
    if (act_w == 4) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start4 = 1'b0; start1 = 1'b0;
  endtask

  // Line-wise bit streams: stream bit k*W lands on the top line of beat k.
  task automatic build(input int flip_line, input int flip_bit, input int end_val);
    int crc[8];
    int nb, v, idx, b;
    logic [7:0] by;
    for (int l = 0; l < 8; l++) crc[l] = 0;
    nb = data_q.size() * 8 / act_w;
    beat_q.delete();
    for (int k = 0; k < nb; k++) begin
      v = 0;
      for (int l = 0; l < act_w; l++) begin
        idx = k * act_w + (act_w - 1 - l);
        by  = data_q[idx / 8];
        b   = int'(by[7 - (idx % 8)]);
        v  |= b << l;
        crc[l] = crc_step(crc[l], b);
      end
      beat_q.push_back(v);
    end
    if (flip_line >= 0) crc[flip_line] ^= (1 << flip_bit);
    for (int i = 0; i < 16; i++) begin
      v = 0;
      for (int l = 0; l < act_w; l++) v |= ((crc[l] >> (15 - i)) & 1) << l;
      beat_q.push_back(v);
    end
    beat_q.push_back(end_val);
  endtask

  task automatic send(input int pre, input int abort_at, input bit mid_start, input bit mid_rst);
    int nb;
    bit aborted;
    nb = data_q.size() * 8 / act_w;
    aborted = 1'b0;
    clr_log();
    blk_size = 12'(data_q.size());
    pulse_start();
    for (int p = 0; p < pre; p++) begin
      if (p == 0 && act_w == 4) set_dat(7);
      else set_dat(int'($urandom_range(1, (1 << act_w) - 1)));
      tick();
    end
    set_dat(0);
    tick();
    for (int i = 0; i < beat_q.size(); i++) begin
      set_dat(beat_q[i]);
      if (mid_start && i == 3) begin
        blk_size = 12'd8;
        if (act_w == 4) start4 = 1'b1; else start1 = 1'b1;
      end
      if (abort_at >= 0 && !aborted && got.size() == abort_at) begin
        abort = 1'b1; aborted = 1'b1;
      end
      if (mid_rst && i == nb + 5) rst = 1'b1;
      tick();
      start4 = 1'b0; start1 = 1'b0; abort = 1'b0;
      blk_size = 12'(data_q.size());
      if (rst) begin
        chk("rst_in_crc_flags", {busy4, rxv4, done4, ce4, te4}, 0);
        chk("rst_in_crc_data", rx4, 0);
        rst = 1'b0;
        break;
      end
    end
    set_dat((1 << act_w) - 1);
    repeat (25) tick();
  endtask

  task automatic check_block(input string tag, input bit exp_ce);
    int bad_iv;
    bad_iv = 0;
    chk({tag, "_nbytes"}, got.size(), data_q.size());
    for (int i = 0; i < got.size() && i < data_q.size(); i++)
      chk({tag, "_byte"}, got[i], data_q[i]);
    for (int i = 1; i < vt.size(); i++)
      if (vt[i] - vt[i-1] != 8 / act_w) bad_iv++;
    chk({tag, "_gap_errs"}, bad_iv, 0);
    chk({tag, "_ndone"}, dn, 1);
    if (vt.size() > 0) chk({tag, "_done_lat"}, dcyc - vt[vt.size()-1], 18);
    chk({tag, "_crc_err"}, ce_a, exp_ce);
    chk({tag, "_tmo_err"}, te_a, 0);
    chk({tag, "_busy_end"}, busy_a, 0);
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; abort = 1'b0;
    blk_size = '0; timeout = '0; dat4 = 4'hF; dat1 = 1'b1;
    tick(); tick();
    chk("reset_u4", {busy4, rxv4, done4, ce4, te4, rx4}, 0);
    chk("reset_u1", {busy1, rxv1, done1, ce1, te1, rx1}, 0);
    rst = 1'b0;
    tick();

    act_w = 4;
    data_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    build(-1, 0, 15); send(3, -1, 0, 0); check_block("good4", 0);
    build(2, 5, 15);  send(2, -1, 0, 0); check_block("dat2_crc_flip", 1);
    build(-1, 0, 11); send(1, -1, 0, 0); check_block("end_1011", 1);
    build(-1, 0, 15); send(2, -1, 1, 0); check_block("start_in_data", 0);

    send(2, 2, 0, 0);
    chk("abort_nbytes", got.size(), 2);
    chk("abort_ndone", dn, 0);
    chk("abort_busy", busy4, 0);
    send(1, -1, 0, 0); check_block("after_abort", 0);

    clr_log(); timeout = 24'd100; blk_size = 12'd4; dat4 = 4'hF;
    pulse_start(); t0 = cyc_n; b100 = -1; b101 = -1;
    repeat (120) begin
      tick();
      if (cyc_n == t0 + 100) b100 = int'(busy4);
      if (cyc_n == t0 + 101) b101 = int'(busy4);
    end
    chk("tmo_ndone", dn, 1);
    chk("tmo_done_cyc", dcyc - t0, 101);
    chk("tmo_nbytes", got.size(), 0);
    chk("tmo_err", te4, 1);
    chk("tmo_crc_err", ce4, 0);
    chk("tmo_busy_before", b100, 1);
    chk("tmo_busy_with_done", b101, 0);

    clr_log(); blk_size = 12'd0;
    pulse_start(); t0 = cyc_n;
    repeat (5) tick();
    chk("zlen_ndone", dn, 1);
    chk("zlen_done_cyc", dcyc - t0, 1);
    chk("zlen_nbytes", got.size(), 0);
    chk("zlen_flags", {ce4, te4}, 0);
    chk("zlen_busy", busy_seen, 0);

    clr_log(); timeout = 24'd0; blk_size = 12'd4;
    pulse_start();
    repeat (10000) tick();
    chk("forever_ndone", dn, 0);
    chk("forever_busy", busy4, 1);
    abort = 1'b1; tick(); abort = 1'b0; tick();
    chk("forever_abort_busy", busy4, 0);
    chk("forever_abort_ndone", dn, 0);

    timeout = 24'd50;
    for (int r = 0; r < 6; r++) begin
      int n, fl;
      n = int'($urandom_range(1, 16));
      data_q.delete();
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
      fl = int'($urandom_range(0, 1));
      if (fl != 0) build(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 15);
      else         build(-1, 0, 15);
      send(int'($urandom_range(0, 10)), -1, 0, 0);
      check_block("rand4", fl[0]);
    end

    data_q = '{8'h11, 8'h22, 8'h33, 8'h5A};
    build(-1, 0, 15); send(1, -1, 0, 1);

    act_w = 1; timeout = 24'd0;
    data_q.delete();
    for (int i = 0; i < 512; i++) data_q.push_back(8'(i));
    build(-1, 0, 1); send(2, -1, 0, 0); check_block("w1_512", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
